// File: rtl/data_memory_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | data_memory_pkg                                                            |
// | Shared types and constants for the multi-cycle data-memory responder.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package data_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         BYTE_LANES      = 4;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic [BYTE_LANES-1:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_memory_responder_if.sv
// +----------------------------------------------------------------------------+
// | data_memory_responder_if                                                   |
// | Request/response bus between the MEM stage and the data-memory responder. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface data_memory_responder_if;
  logic        ReqValid;
  logic        ReqWrite;
  logic        ReqByte;
  logic [31:0] ReqAddress;
  logic [31:0] ReqWriteData;
  logic        ReqReady;
  logic        RespValid;
  logic [31:0] RespData;
  logic        AddrError;
  logic        Busy;

  modport master (
    output ReqValid, ReqWrite, ReqByte, ReqAddress, ReqWriteData,
    input  ReqReady, RespValid, RespData, AddrError, Busy
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqByte, ReqAddress, ReqWriteData,
    output ReqReady, RespValid, RespData, AddrError, Busy
  );
endinterface

`default_nettype wire

// File: rtl/data_memory_responder_mem_word_array.sv
// +----------------------------------------------------------------------------+
// | mem_word_array                                                             |
// | Word-wide storage, synchronous byte-enabled write, combinational read.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mem_word_array
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  assign rdata = mem[addr];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < BYTE_LANES; lane++) begin
      if (we && be[lane]) begin
        mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_memory_responder.sv
// +----------------------------------------------------------------------------+
// | data_memory_responder                                                      |
// | Multi-cycle load/store slave with programmable latency and Busy stall.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  data_memory_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 2) ? LATENCY - 2 : 0);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             write_q, byte_q;

  logic             ready_int, accept, misaligned, do_access, err_resp;
  logic [IDX_W+1:0] acc_addr;
  logic [31:0]      acc_wdata, rd_word, load_data, mem_wdata;
  logic             acc_write, acc_byte, mem_we;
  logic [1:0]       lane;
  logic [BYTE_LANES-1:0] mem_be;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^bus.ReqAddress[31:IDX_W+2];

  assign ready_int  = (state == IDLE) && !Rst;
  assign accept     = bus.ReqValid && ready_int;
  assign misaligned = !bus.ReqByte && ((bus.ReqAddress[1:0] & WORD_ALIGN_MASK) != 2'b00);

  // With LATENCY=1 the access happens on the accept edge, straight from the bus.
  assign acc_addr  = (state == IDLE) ? bus.ReqAddress[IDX_W+1:0] : addr_q;
  assign acc_wdata = (state == IDLE) ? bus.ReqWriteData : wdata_q;
  assign acc_write = (state == IDLE) ? bus.ReqWrite : write_q;
  assign acc_byte  = (state == IDLE) ? bus.ReqByte : byte_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    do_access  = 1'b0;
    err_resp   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            err_resp   = 1'b1;
            state_next = RESP;
          end else if (LATENCY == 1) begin
            do_access  = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = CNT_LOAD;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          do_access  = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign lane      = acc_addr[1:0];
  assign mem_we    = do_access && acc_write;
  assign mem_be    = acc_byte ? lane_mask(lane) : {BYTE_LANES{1'b1}};
  assign mem_wdata = acc_byte ? {BYTE_LANES{acc_wdata[7:0]}} : acc_wdata;
  assign load_data = acc_byte ? {24'b0, rd_word[8*lane +: 8]} : rd_word;

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk   (Clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (acc_addr[IDX_W+1:2]),
    .wdata (mem_wdata),
    .rdata (rd_word)
  );

  // Response registers are rewritten every cycle so they read 0 outside RESP.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      byte_q        <= 1'b0;
      bus.RespValid <= 1'b0;
      bus.RespData  <= '0;
      bus.AddrError <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.ReqAddress[IDX_W+1:0];
        wdata_q <= bus.ReqWriteData;
        write_q <= bus.ReqWrite;
        byte_q  <= bus.ReqByte;
      end
      bus.RespValid <= do_access || err_resp;
      bus.RespData  <= (do_access && !acc_write) ? load_data : 32'h0;
      bus.AddrError <= err_resp;
    end
  end

  assign bus.ReqReady = ready_int;
  assign bus.Busy     = !Rst && (((state == IDLE) && bus.ReqValid) || (state == WAIT));

endmodule

`default_nettype wire
